// File: rtl/tdm_transmission_pkg.sv
// Shared constants and helpers for the TDM transmission block.
// Holds the default word width and channel count, plus the select-width
// function used by the interface and the top level.
package tdm_transmission_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 8;

    // Select width is clog2(channels), but never narrower than one bit.
    function automatic int sel_w(input int channels);
        int w;
        w = $clog2(channels);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tdm_transmission_if.sv
// Bundle of the producer and consumer signals of the TDM transmission block.
// slave modport: block side (takes in_*, auto_mode, out_ack; drives in_ready, out_*, cur_ch, sel_err).
// master modport: environment side, the mirror image of slave.
interface tdm_transmission_if
    import tdm_transmission_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
);
    localparam int SEL_W = sel_w(CHANNELS);

    logic [WIDTH-1:0]          in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      in_valid;
    logic                      in_ready;
    logic                      auto_mode;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ack;
    logic [SEL_W-1:0]          cur_ch;
    logic                      sel_err;

    modport slave (
        input  in_data, in_sel, in_valid, auto_mode, out_ack,
        output in_ready, out_data, out_valid, cur_ch, sel_err
    );

    modport master (
        output in_data, in_sel, in_valid, auto_mode, out_ack,
        input  in_ready, out_data, out_valid, cur_ch, sel_err
    );

endinterface

// File: rtl/tdm_channel_slot.sv
// One TDM channel: a holding register for the last word written plus its valid flag.
// Latency: a write is visible on dat_o/vld_o one cycle later.
// Backpressure: none here; the top level only writes when the slot is free or being acked.
// Ports: clk/rst, wr_en_i/wr_dat_i (load), ack_i (consume), dat_o/vld_o (held word).
module tdm_channel_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             ack_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             vld_o
);

    logic [WIDTH-1:0] dat_q, dat_d;
    logic             vld_q, vld_d;

    // A write wins over an ack so a same-cycle ack+write keeps the slot full.
    // Acks only ever clear the flag; the data stays put until overwritten.
    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        if (wr_en_i) begin
            dat_d = wr_dat_i;
            vld_d = 1'b1;
        end else if (ack_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end
    end

    assign dat_o = dat_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/tdm_transmission.sv
// TDM transmitter: steers each accepted word into one of CHANNELS holding slots.
// Latency: one cycle from transfer to out_valid/out_data; sel_err pulses the cycle after.
// Backpressure: in_ready drops only while the target slot is full and not being acked.
// Ports: clk/rst plain; bus (slave modport) carries input handshake, channel outputs, acks,
// the round-robin pointer cur_ch and the out-of-range select pulse sel_err.
module tdm_transmission
    import tdm_transmission_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic               clk,
    input  logic               rst,
    tdm_transmission_if.slave  bus
);

    localparam int             SEL_W  = sel_w(CHANNELS);
    localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

    logic [SEL_W-1:0]          cur_ch_q, cur_ch_d;
    logic                      sel_err_q, sel_err_d;
    logic [SEL_W-1:0]          tgt;
    logic                      in_range;
    logic                      tgt_vld;
    logic                      tgt_ack;
    logic                      in_ready;
    logic                      xfer;
    logic [CHANNELS-1:0]       wr_en;
    logic [CHANNELS-1:0]       vld_vec;
    logic [WIDTH-1:0]          slot_dat [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] dat_flat;

    always_comb begin
        tgt       = bus.auto_mode ? cur_ch_q : bus.in_sel;
        // Extra top bit keeps the compare meaningful when CHANNELS is a power of two.
        in_range  = {1'b0, tgt} < CH_LIM;
        tgt_vld   = 1'b0;
        tgt_ack   = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (tgt == SEL_W'(k)) begin
                tgt_vld = vld_vec[k];
                tgt_ack = bus.out_ack[k];
            end
        end
        // Out-of-range words are always accepted so they can be dropped and flagged.
        in_ready  = !in_range || !tgt_vld || tgt_ack;
        xfer      = bus.in_valid && in_ready;
        for (int k = 0; k < CHANNELS; k++) begin
            wr_en[k] = xfer && in_range && (tgt == SEL_W'(k));
        end
        sel_err_d = xfer && !in_range;
        // Pointer only moves on an auto-mode transfer, so a stall holds it on the busy slot.
        cur_ch_d  = cur_ch_q;
        if (xfer && bus.auto_mode) begin
            cur_ch_d = (cur_ch_q == SEL_W'(CHANNELS - 1)) ? '0 : cur_ch_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_ch_q  <= '0;
            sel_err_q <= 1'b0;
        end else begin
            cur_ch_q  <= cur_ch_d;
            sel_err_q <= sel_err_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        tdm_channel_slot #(.WIDTH(WIDTH)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .wr_en_i  (wr_en[k]),
            .wr_dat_i (bus.in_data),
            .ack_i    (bus.out_ack[k]),
            .dat_o    (slot_dat[k]),
            .vld_o    (vld_vec[k])
        );
    end

    always_comb begin
        dat_flat = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            dat_flat[k*WIDTH +: WIDTH] = slot_dat[k];
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = dat_flat;
    assign bus.out_valid = vld_vec;
    assign bus.cur_ch    = cur_ch_q;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_tdm_transmission.sv
// Bench for tdm_transmission: an 8-channel instance driven by directed steps and a
// long random run against per-channel expected-word queues, plus a 6-channel instance
// for out-of-range explicit selects.
module tb_tdm_transmission;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdm_transmission_if #(.WIDTH(8), .CHANNELS(8)) a_if ();
    tdm_transmission_if #(.WIDTH(8), .CHANNELS(6)) b_if ();

    tdm_transmission #(.WIDTH(8), .CHANNELS(8)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    tdm_transmission #(.WIDTH(8), .CHANNELS(6)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    int passed = 0;
    int total  = 0;

    // Expected words per channel of instance A: pushed on transfer, popped on ack.
    logic [7:0] sb [8][$];
    int         m_cur = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_vld();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = (sb[k].size() != 0);
        return v;
    endfunction

    // One clock of instance A: drive at the falling edge, check ready/acked data,
    // update the model, then check registered outputs at the next falling edge.
    task automatic cycle(input logic v, input logic am, input logic [2:0] sel,
                         input logic [7:0] d, input logic [7:0] ack);
        int   tgt;
        logic exp_rdy;
        a_if.in_valid  = v;
        a_if.auto_mode = am;
        a_if.in_sel    = sel;
        a_if.in_data   = d;
        a_if.out_ack   = ack;
        #1;
        tgt     = am ? m_cur : int'(sel);
        exp_rdy = (sb[tgt].size() == 0) || ack[tgt];
        chk("in_ready", a_if.in_ready, exp_rdy);
        for (int k = 0; k < 8; k++) begin
            if (ack[k] && sb[k].size() != 0)
                chk("ack_data", a_if.out_data[k*8 +: 8], sb[k].pop_front());
        end
        if (v && exp_rdy) begin
            sb[tgt].push_back(d);
            if (am) m_cur = (m_cur + 1) % 8;
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", a_if.out_valid, model_vld());
        chk("cur_ch", a_if.cur_ch, m_cur);
        chk("sel_err_a", a_if.sel_err, 1'b0);
    endtask

    initial begin
        a_if.in_valid = 0; a_if.auto_mode = 1; a_if.in_sel = 0; a_if.in_data = 0; a_if.out_ack = 0;
        b_if.in_valid = 0; b_if.auto_mode = 0; b_if.in_sel = 0; b_if.in_data = 0; b_if.out_ack = 0;

        // Reset state
        #12;
        chk("rst_valid", a_if.out_valid, 0);
        chk("rst_data", a_if.out_data, 0);
        chk("rst_cur", a_if.cur_ch, 0);
        chk("rst_err", a_if.sel_err, 0);
        chk("rst_b_valid", b_if.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        // Auto fill of all eight channels, first transfer right after reset
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 8'(i), 0);
        for (int k = 0; k < 8; k++) chk("fill_data", a_if.out_data[k*8 +: 8], 64'(k));
        chk("fill_valid", a_if.out_valid, 8'hFF);
        chk("fill_cur", a_if.cur_ch, 0);
        // Ninth offer stalls on the occupied channel 0
        cycle(1, 1, 0, 8'h08, 0);
        chk("full_ready", a_if.in_ready, 0);
        chk("stall_cur", a_if.cur_ch, 0);

        // Ack and refill channel 0 in the same cycle
        cycle(1, 1, 0, 8'hA5, 8'h01);
        chk("refill_data", a_if.out_data[7:0], 8'hA5);
        chk("refill_valid", a_if.out_valid, 8'hFF);
        chk("refill_cur", a_if.cur_ch, 1);

        // Drain everything
        cycle(0, 1, 0, 0, 8'hFF);
        chk("drain_valid", a_if.out_valid, 0);

        // Explicit write to channel 5, ack it, data persists; stray ack ignored
        cycle(1, 0, 5, 8'h3C, 0);
        cycle(0, 0, 0, 0, 8'h20);
        chk("ack5_valid", a_if.out_valid[5], 0);
        chk("ack5_data", a_if.out_data[47:40], 8'h3C);
        chk("toggle_cur", a_if.cur_ch, 1);
        cycle(0, 1, 0, 0, 8'h20);
        chk("stray_ack_data", a_if.out_data[47:40], 8'h3C);

        // Mid-operation asynchronous reset with channels 0..3 full
        for (int i = 0; i < 4; i++) cycle(1, 0, 3'(i), 8'h50 + 8'(i), 0);
        chk("pre_rst_valid", a_if.out_valid, 8'h0F);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", a_if.out_valid, 0);
        chk("async_data", a_if.out_data, 0);
        chk("async_cur", a_if.cur_ch, 0);
        for (int k = 0; k < 8; k++) sb[k].delete();
        m_cur = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 1, 0, 8'h77, 0);
        chk("post_rst_data", a_if.out_data[7:0], 8'h77);

        // Random traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  8'($urandom), 8'($urandom) & 8'($urandom));
        end
        a_if.in_valid = 0;
        a_if.out_ack  = 0;

        // Six-channel instance: out-of-range explicit selects
        b_if.in_sel = 2; b_if.in_data = 8'h11; b_if.in_valid = 1;
        #1 chk("b_ready", b_if.in_ready, 1);
        @(posedge clk); @(negedge clk);
        b_if.in_sel = 7; b_if.in_data = 8'hEE;
        #1 chk("b_oor_ready", b_if.in_ready, 1);
        chk("b_valid", b_if.out_valid, 6'h04);
        @(posedge clk); @(negedge clk);
        b_if.in_sel = 6;
        #1 chk("b_err_pulse", b_if.sel_err, 1);
        chk("b_oor_valid", b_if.out_valid, 6'h04);
        chk("b_oor_data", b_if.out_data[23:16], 8'h11);
        @(posedge clk); @(negedge clk);
        b_if.in_valid = 0;
        #1 chk("b_err_edge", b_if.sel_err, 1);
        chk("b_edge_valid", b_if.out_valid, 6'h04);
        @(posedge clk); @(negedge clk);
        chk("b_err_clear", b_if.sel_err, 0);
        chk("b_cur", b_if.cur_ch, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tdm_transmission.md
TDM_TRANSMISSION -- requirements
Module: tdm_transmission

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter CHANNELS, default 8, giving the number of output channels; legal range 2..64.
REQ-003 The block SHALL derive localparam SEL_W = max(1, clog2(CHANNELS)) for the select width.
REQ-004 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  WIDTH  word to transmit.
REQ-007 in_sel  input  SEL_W  target channel; used only when auto_mode=0.
REQ-008 in_valid  input  1  in_data/in_sel are valid this cycle.
REQ-009 in_ready  output  1  the block accepts the offered word this cycle.
REQ-010 auto_mode  input  1  1 = round-robin channel sequencing; 0 = explicit in_sel.
REQ-011 out_data  output  CHANNELS*WIDTH  flat vector; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-012 out_valid  output  CHANNELS  bit k set = channel k holds an unacknowledged word.
REQ-013 out_ack  input  CHANNELS  bit k consumes channel k's word when out_valid[k]=1.
REQ-014 cur_ch  output  SEL_W  current round-robin channel pointer.
REQ-015 sel_err  output  1  one-cycle pulse when an explicit in_sel >= CHANNELS is accepted.

Function
REQ-016 The target channel SHALL be cur_ch when auto_mode=1, and in_sel when auto_mode=0.
REQ-017 in_ready SHALL be combinational: 1 when the target is out of range, or when out_valid[target]=0, or when out_ack[target]=1 in the same cycle; otherwise 0.
REQ-018 A transfer SHALL occur on a clock edge where in_valid=1 and in_ready=1.
REQ-019 On a transfer to a valid channel k, out_data[k] SHALL load in_data and out_valid[k] SHALL be 1 from the next cycle (latency 1).
REQ-020 out_data[k] SHALL hold its value until the next transfer to channel k; an ack SHALL NOT clear the data.
REQ-021 out_ack[k] with out_valid[k]=1 and no transfer to k SHALL clear out_valid[k] at the next edge.
REQ-022 On a simultaneous ack and transfer to the same channel, the new word SHALL load and out_valid[k] SHALL remain 1.
REQ-023 out_ack[k] with out_valid[k]=0 SHALL be ignored.
REQ-024 A transfer with an explicit target >= CHANNELS SHALL be discarded, change no channel, and pulse sel_err for exactly one cycle.
REQ-025 cur_ch SHALL increment only on a transfer made with auto_mode=1, and SHALL wrap from CHANNELS-1 to 0.
REQ-026 A stalled auto-mode transfer SHALL stall on cur_ch; the pointer SHALL never skip an occupied channel.
REQ-027 Toggling auto_mode SHALL NOT modify cur_ch or any channel state.
REQ-028 Transfers and acks on different channels in the same cycle SHALL all take effect independently.

Reset
REQ-029 While rst=1, out_valid, out_data, cur_ch and sel_err SHALL be 0, asynchronously to clk.
REQ-030 A reset asserted mid-operation SHALL discard all held words without emitting out_valid.
REQ-031 After rst deasserts, the first transfer SHALL be allowed on the next rising edge.

Structure
REQ-032 Package tdm_transmission_pkg SHALL hold the default WIDTH and CHANNELS constants and the sel_w() width function.
REQ-033 Sub-module tdm_channel_slot SHALL implement one channel's holding register and valid flag, instantiated CHANNELS times by a generate loop.
REQ-034 The round-robin pointer, target decode, in_ready and sel_err logic SHALL reside in the top level.

Verification
REQ-035 Defaults, auto_mode=1, in_valid held for 8 cycles with data 0x00..0x07, no acks -> channels 0..7 hold 0x00..0x07, out_valid=0xFF, cur_ch=0, in_ready=0 on the 9th cycle.
REQ-036 Continuing from REQ-035, ack channel 0 and offer 0xA5 in the same cycle -> in_ready=1, out_data[0]=0xA5, out_valid[0] stays 1, cur_ch=1.
REQ-037 CHANNELS=6, auto_mode=0, in_sel=7, in_valid=1 -> in_ready=1, one-cycle sel_err pulse, out_valid unchanged.
REQ-038 auto_mode=0, write 0x3C to channel 5, ack it -> out_valid[5]=0 one cycle after the ack, out_data[5] stays 0x3C.
REQ-039 Assert rst asynchronously between edges with out_valid=0x0F -> outputs clear before the next edge; cur_ch=0.
REQ-040 Random in_valid/in_sel/auto_mode/out_ack for 10k cycles against a scoreboard -> no lost, duplicated or overwritten unacknowledged words.
